serial_to_parallel_align: RTL and testbench

- Receive-side stage directly upstream of the 1:2 byte demux. Feeds the demux's in0 and in0_valid inputs.
- Deserialises a 1-bit lane into bytes, MSB first.
- Hunts for the COMMA symbol to find byte boundaries. After LOCK_COUNT consecutive aligned commas it declares the link active.
- While active, it forwards every non-comma byte with a one-cycle valid strobe. Commas are treated as idle.

---
 rtl/serial_to_parallel_align.sv | 81 ++++++++
 tb/tb_serial_to_parallel_align.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_align.sv
// serial_to_parallel_align: deserialises a 1-bit lane MSB first and locks onto COMMA-delimited byte boundaries
// Ports:
//   clk       - one serial bit sampled per rising edge
//   reset     - asynchronous, active-low
//   data_in   - serial bit stream, MSB of each byte first
//   data_out  - last payload byte, held between strobes
//   valid_out - one-cycle strobe marking a new payload byte on data_out
//   active    - high while lock is held
module serial_to_parallel_align #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);
    typedef enum logic [1:0] {HUNT, ALIGN, ACTIVE} state_t;
    localparam logic [3:0] LOCK = 4'(LOCK_COUNT);
    state_t     state;
    logic [7:0] shift;
    logic [2:0] bit_cnt;
    logic [3:0] comma_cnt;
    logic [7:0] win;
    logic       is_comma;
    logic       boundary;
    assign win      = {shift[6:0], data_in};
    assign is_comma = win == COMMA;
    assign boundary = bit_cnt == 3'd7;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= HUNT;
            shift     <= 8'h00;
            bit_cnt   <= 3'd0;
            comma_cnt <= 4'd0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            shift     <= win;
            valid_out <= 1'b0;
            case (state)
                HUNT: begin
                    // bit-granular search; a hit defines the byte boundary
                    if (is_comma) begin
                        bit_cnt   <= 3'd0;
                        comma_cnt <= 4'd1;
                        state     <= LOCK == 4'd1 ? ACTIVE : ALIGN;
                        active    <= LOCK == 4'd1;
                    end
                end
                ALIGN: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary) begin
                        if (is_comma) begin
                            comma_cnt <= comma_cnt == 4'hF ? comma_cnt : comma_cnt + 4'd1;
                            if (comma_cnt + 4'd1 == LOCK) begin
                                state  <= ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            state     <= HUNT;
                            comma_cnt <= 4'd0;
                        end
                    end
                end
                ACTIVE: begin
                    // commas are idle fill; lock is only lost through reset
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary && !is_comma) begin
                        data_out  <= win;
                        valid_out <= 1'b1;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_to_parallel_align.sv
// tb_serial_to_parallel_align: checks serial_to_parallel_align against a cycle-level reference model
module tb_serial_to_parallel_align;
    localparam logic [7:0] COMMA = 8'hBC;
    localparam int LOCK = 4;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    // reference model: window from the last eight bits, boundaries as multiples of 8 from the anchor
    bit         bits[$];
    int         n, anchor, commas;
    bit         hunting, locked;
    logic [7:0] m_data;
    bit         m_valid;
    logic [7:0] sq[$];
    int         cq[$];
    serial_to_parallel_align #(.COMMA(COMMA), .LOCK_COUNT(LOCK)) dut (
        .clk(clk), .reset(reset), .data_in(data_in),
        .data_out(data_out), .valid_out(valid_out), .active(active)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        bits.delete();
        n = 0; anchor = 0; commas = 0;
        hunting = 1; locked = 0;
        m_data = 8'h00; m_valid = 0;
    endtask
    task automatic model_step(input bit b);
        logic [7:0] w;
        bits.push_back(b);
        if (bits.size() > 8) void'(bits.pop_front());
        w = 8'h00;
        foreach (bits[i]) w = {w[6:0], bits[i]};
        m_valid = 0;
        if (hunting) begin
            if (w == COMMA) begin
                hunting = 0; anchor = n; commas = 1; locked = (LOCK == 1);
            end
        end else if ((n - anchor) % 8 == 0) begin
            if (locked) begin
                if (w != COMMA) begin m_data = w; m_valid = 1; end
            end else if (w == COMMA) begin
                commas++;
                if (commas == LOCK) locked = 1;
            end else begin
                hunting = 1; commas = 0;
            end
        end
        n++;
    endtask
    task automatic send_bit(input bit b);
        data_in = b;
        @(posedge clk);
        model_step(b);
        #1;
        check("data_out", 32'(data_out), 32'(m_data));
        check("valid_out", 32'(valid_out), 32'(m_valid));
        check("active", 32'(active), 32'(locked));
        if (valid_out) begin sq.push_back(data_out); cq.push_back(cyc); end
        cyc++;
    endtask
    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask
    task automatic clear_log();
        sq.delete(); cq.delete();
    endtask
    task automatic apply_reset();
        reset = 1'b0;
        #1;
        check("rst_async_data", 32'(data_out), 32'h00);
        check("rst_async_valid", 32'(valid_out), 32'h0);
        check("rst_async_active", 32'(active), 32'h0);
        for (int i = 0; i < 3; i++) begin
            data_in = ~data_in;
            @(posedge clk);
            #1;
            check("rst_data", 32'(data_out), 32'h00);
            check("rst_valid", 32'(valid_out), 32'h0);
            check("rst_active", 32'(active), 32'h0);
        end
        model_reset();
        reset = 1'b1;
    endtask
    initial begin
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();
        // basic lock
        clear_log();
        send_bit(1); send_bit(0); send_bit(1);
        for (int i = 0; i < 3; i++) send_byte(COMMA);
        check("basic_pre_active", 32'(active), 32'h0);
        send_byte(COMMA);
        check("basic_active", 32'(active), 32'h1);
        send_byte(8'h5A); send_byte(8'hA5);
        check("basic_count", sq.size(), 2);
        if (sq.size() == 2) begin
            check("basic_b0", 32'(sq[0]), 32'h5A);
            check("basic_b1", 32'(sq[1]), 32'hA5);
            check("basic_gap", cq[1] - cq[0], 8);
        end
        // broken alignment
        apply_reset();
        clear_log();
        send_byte(COMMA); send_byte(COMMA); send_byte(8'h3C);
        check("broken_active", 32'(active), 32'h0);
        for (int i = 0; i < 4; i++) send_byte(COMMA);
        check("broken_relock", 32'(active), 32'h1);
        send_byte(8'h77);
        check("broken_count", sq.size(), 1);
        if (sq.size() == 1) check("broken_b0", 32'(sq[0]), 32'h77);
        // idle suppression
        clear_log();
        send_byte(8'h11); send_byte(COMMA); send_byte(COMMA);
        check("idle_hold", 32'(data_out), 32'h11);
        send_byte(8'h22);
        check("idle_count", sq.size(), 2);
        if (sq.size() == 2) begin
            check("idle_b0", 32'(sq[0]), 32'h11);
            check("idle_b1", 32'(sq[1]), 32'h22);
            check("idle_gap", cq[1] - cq[0], 24);
        end
        // comma straddling a boundary is payload
        clear_log();
        send_byte(8'h0B); send_byte(8'hC0);
        check("mis_count", sq.size(), 2);
        if (sq.size() == 2) begin
            check("mis_b0", 32'(sq[0]), 32'h0B);
            check("mis_b1", 32'(sq[1]), 32'hC0);
        end
        check("mis_active", 32'(active), 32'h1);
        // random traffic while locked
        for (int i = 0; i < 40; i++)
            send_byte($urandom_range(3) == 0 ? COMMA : 8'($urandom));
        // reset three bits into a payload byte
        send_bit(0); send_bit(1); send_bit(0);
        apply_reset();
        clear_log();
        for (int i = 0; i < 3; i++) send_byte(COMMA);
        send_byte(8'h33);
        check("mid_none", sq.size(), 0);
        check("mid_inactive", 32'(active), 32'h0);
        for (int i = 0; i < 4; i++) send_byte(COMMA);
        send_byte(8'h33);
        check("mid_count", sq.size(), 1);
        // random junk, random lock offset, random payload
        for (int k = 0; k < 3; k++) begin
            apply_reset();
            for (int i = 0; i < 5 + int'($urandom_range(20)); i++) send_bit(1'($urandom));
            for (int i = 0; i < LOCK; i++) send_byte(COMMA);
            for (int i = 0; i < 30; i++)
                send_byte($urandom_range(4) == 0 ? COMMA : 8'($urandom));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
